// File: rtl/datapath_v1.sv
// datapath_v1: accumulator datapath (PC/IR/ACC/z/c/16x8 regfile, ALU, conditional jumps); optional dbg_acc/dbg_pc outputs under DATAPATH_DEBUG_EN
module datapath_v1 (
  input  logic       clk,
  input  logic       CLB,
  input  logic       LoadIR,
  input  logic       IncPC,
  input  logic       SelPC,
  input  logic       LoadPC,
  input  logic       LoadReg,
  input  logic       LoadAcc,
  input  logic [1:0] SelAcc,
  input  logic [3:0] SelALU,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [3:0] op,
  output logic       z,
  output logic       c
`ifdef DATAPATH_DEBUG_EN
  ,
  output logic [7:0] dbg_acc,
  output logic [7:0] dbg_pc
`endif
);
  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, NOR = 4'b0011, SHL = 4'b1011, SHR = 4'b1100;
  localparam logic [3:0] JZRS = 4'b0110, JZIM = 4'b0111, JCRS = 4'b1000, JCIM = 4'b1010;
  logic [7:0] pc, ir, acc, b, r, acc_nxt, target;
  logic [7:0] rf [16];
  logic       cy, taken;
  assign imem_addr = pc;
  assign op        = ir[7:4];
`ifdef DATAPATH_DEBUG_EN
  assign dbg_acc = acc;
  assign dbg_pc  = pc;
`endif
  always_comb begin
    b = rf[ir[3:0]];
    {cy, r} = {1'b0, acc};
    case (SelALU)
      ADD:     {cy, r} = {1'b0, acc} + {1'b0, b};
      SUB:     {cy, r} = {1'b0, acc} - {1'b0, b};
      NOR:     {cy, r} = {1'b0, ~(acc | b)};
      SHL:     {cy, r} = {acc, 1'b0};
      SHR:     {r, cy} = {1'b0, acc};
      default: {cy, r} = {1'b0, acc};
    endcase
    acc_nxt = SelAcc[1] ? (SelAcc[0] ? {4'b0, ir[3:0]} : b) : r;
    target  = SelPC ? b : {4'b0, ir[3:0]};
    taken   = LoadPC && ((z && (op == JZRS || op == JZIM)) || (c && (op == JCRS || op == JCIM)));
  end
  always_ff @(posedge clk) begin
    if (CLB) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      z   <= 1'b0;
      c   <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (LoadIR) ir <= imem_data;
      if (taken) pc <= target;
      else if (IncPC) pc <= pc + 8'd1;
      if (LoadAcc && SelAcc != 2'b01) acc <= acc_nxt;
      if (LoadAcc && SelAcc == 2'b00) begin
        z <= (r == 8'd0);
        c <= cy;
      end
      if (LoadReg) rf[ir[3:0]] <= acc;
    end
  end
endmodule

// File: tb/tb_datapath_v1.sv
// tb_datapath_v1: scoreboard bench for datapath_v1 with a behavioural model
module tb_datapath_v1;
  logic       clk = 1'b0;
  logic       CLB = 1'b1, LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0, LoadReg = 1'b0, LoadAcc = 1'b0;
  logic [1:0] SelAcc = 2'b00;
  logic [3:0] SelALU = 4'b0000;
  logic [7:0] imem_addr, imem_data = 8'h00;
  logic [3:0] op;
  logic       z, c;
`ifdef DATAPATH_DEBUG_EN
  logic [7:0] dbg_acc, dbg_pc;
`endif
  datapath_v1 dut (
    .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .imem_addr(imem_addr), .imem_data(imem_data), .op(op), .z(z), .c(c)
`ifdef DATAPATH_DEBUG_EN
    , .dbg_acc(dbg_acc), .dbg_pc(dbg_pc)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] op;
    logic       z;
    logic       c;
    logic [7:0] acc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;
  logic [7:0] m_pc, m_ir, m_acc;
  logic [7:0] m_rf [16];
  logic       m_z, m_c;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", imem_addr, e.pc);
      chk("op", op, e.op);
      chk("z", z, e.z);
      chk("c", c, e.c);
`ifdef DATAPATH_DEBUG_EN
      chk("dbg_acc", dbg_acc, e.acc);
      chk("dbg_pc", dbg_pc, e.pc);
`endif
    end
  end
  task automatic cyc(input logic clb, lir, inc, spc, lpc, lreg, lacc, input logic [1:0] sa,
                     input logic [3:0] alu, input logic [7:0] d);
    int a, b, res;
    logic cy, taken;
    logic [7:0] npc, nacc;
    @(negedge clk);
    CLB = clb; LoadIR = lir; IncPC = inc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sa; SelALU = alu; imem_data = d;
    if (clb) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
    end else begin
      a = m_acc;
      b = m_rf[m_ir[3:0]];
      cy = 0;
      case (alu)
        4'd1:    begin res = a + b; cy = res > 255; end
        4'd2:    begin res = a - b; cy = a < b; end
        4'd3:    res = 255 - (a | b);
        4'd11:   begin res = a * 2; cy = a >= 128; end
        4'd12:   begin res = a / 2; cy = (a % 2) == 1; end
        default: res = a;
      endcase
      res = ((res % 256) + 256) % 256;
      taken = lpc && ((m_z && (m_ir[7:4] == 6 || m_ir[7:4] == 7)) ||
                      (m_c && (m_ir[7:4] == 8 || m_ir[7:4] == 10)));
      npc = taken ? (spc ? 8'(b) : {4'h0, m_ir[3:0]}) : inc ? 8'((m_pc + 1) % 256) : m_pc;
      nacc = !lacc ? m_acc : sa == 2'b00 ? 8'(res) : sa == 2'b10 ? 8'(b) :
             sa == 2'b11 ? {4'h0, m_ir[3:0]} : m_acc;
      if (lacc && sa == 2'b00) begin
        m_z = (res == 0);
        m_c = cy;
      end
      if (lreg) m_rf[m_ir[3:0]] = m_acc;
      m_acc = nacc;
      m_pc = npc;
      if (lir) m_ir = d;
    end
    q.push_back({m_pc, m_ir[7:4], m_z, m_c, m_acc});
  endtask
  task automatic ins(input logic [7:0] d, input logic lreg, lacc, input logic [1:0] sa,
                     input logic [3:0] alu, input logic lpc, spc, inc);
    cyc(0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, d);
    cyc(0, 0, inc, spc, lpc, lreg, lacc, sa, alu, d);
  endtask
  task automatic ldim(input logic [3:0] n);
    ins({4'hD, n}, 0, 1, 2'b11, 4'h0, 0, 0, 0);
  endtask
  task automatic alu_op(input logic [3:0] code, input logic [3:0] rr);
    ins({code, rr}, 0, 1, 2'b00, code, 0, 0, 0);
  endtask
  task automatic mova(input logic [3:0] rr);
    ins({4'h5, rr}, 1, 0, 2'b00, 4'h0, 0, 0, 0);
  endtask
  task automatic shl4();
    repeat (4) alu_op(4'hB, 4'h0);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00);
    ldim(4'h5);
    settle();
    chk("ldim_z", z, 0);
    mova(4'h1);
    alu_op(4'h2, 4'h1);
    settle();
    chk("sub_z", z, 1);
    ins(8'h79, 0, 0, 2'b00, 4'h0, 1, 0, 1);
    settle();
    chk("jzim_pc", imem_addr, 8'h09);
    repeat (24) cyc(0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00);
    ins(8'hA3, 0, 0, 2'b00, 4'h0, 1, 0, 0);
    settle();
    chk("jcim_nt_pc", imem_addr, 8'h21);
    ldim(4'h2); shl4(); mova(4'h3);
    ldim(4'hF); shl4(); alu_op(4'h1, 4'h3);
    settle();
    chk("add_c", c, 1);
    ldim(4'h3); shl4(); mova(4'h5);
    ldim(4'hC); alu_op(4'h1, 4'h5);
    mova(4'hA);
    alu_op(4'h2, 4'hA);
    ins(8'h6A, 0, 0, 2'b00, 4'h0, 1, 1, 0);
    settle();
    chk("jzrs_pc", imem_addr, 8'h3C);
    ldim(4'h0); alu_op(4'h3, 4'h0); mova(4'h4); alu_op(4'h2, 4'h4);
    ins(8'h64, 0, 0, 2'b00, 4'h0, 1, 1, 0);
    settle();
    chk("pc_ff", imem_addr, 8'hFF);
    cyc(0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00);
    settle();
    chk("pc_wrap", imem_addr, 8'h00);
    ldim(4'h9); shl4(); mova(4'h7);
    cyc(0, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'hD7);
    cyc(1, 1, 1, 1, 1, 1, 1, 2'b11, 4'h1, 8'h87);
    settle();
    chk("rst_pc", imem_addr, 8'h00);
    chk("rst_op", op, 4'h0);
    repeat (400)
      cyc($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom));
    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
